// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: FSM state encoding,
// clock/baud relationships and the default byte width.
package uart_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int CLK_HZ       = 50_000_000;
   localparam int BAUD         = 115200;
   // One bit time in system clocks (50e6 / 115200, truncated to 434).
   localparam int BIT_CYCLES   = CLK_HZ / BAUD;
   // Start + 8 data + stop bits.
   localparam int FRAME_CYCLES = BIT_CYCLES * 10;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// searching upward from i_rr_ptr with wrap-around. Shared with the RX side.
module rr_pick #(
   parameter int N_REQ = 4
)(
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_rr_ptr,
   output logic [$clog2(N_REQ)-1:0] o_grant,
   output logic                     o_any_req
);

   localparam int IDX_W = $clog2(N_REQ);

   // Index i_rr_ptr + off folded back into 0..N_REQ-1 (both operands < N_REQ).
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return s[IDX_W-1:0];
   endfunction

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      o_grant   = '0;
      o_any_req = |i_req;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[wrap_idx(i_rr_ptr, k)]) o_grant = wrap_idx(i_rr_ptr, k);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte producers.
// Grants one byte per frame, drives the core's start/busy/done handshake,
// aborts frames whose done never arrives, and enforces an idle gap between
// frames so receivers get line-idle time.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int GAP_CYCLES     = BIT_CYCLES,
   parameter int TIMEOUT_CYCLES = 5000
)(
   input  logic                      clock_50mhz,
   input  logic                      reset_pin,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ack,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_start,
   input  logic                      tx_busy,
   input  logic                      tx_done,
   output logic [$clog2(N_REQ)-1:0]  owner,
   output logic                      active,
   output logic                      timeout_err
);

   localparam int OWN_W    = $clog2(N_REQ);
   localparam int CNT_MAX  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_t              r_state;
   logic [OWN_W-1:0]    r_rr_ptr;
   logic [OWN_W-1:0]    r_owner;
   logic [N_REQ-1:0]    r_req_ack;
   logic [DATA_W-1:0]   r_tx_data;
   logic                r_tx_start;
   logic                r_active;
   logic                r_timeout_err;
   logic [CNT_W-1:0]    r_gap_cnt;
   logic [CNT_W-1:0]    r_wdog_cnt;

   logic [OWN_W-1:0]    w_grant;
   logic                w_any_req;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .i_req     (req),
      .i_rr_ptr  (r_rr_ptr),
      .o_grant   (w_grant),
      .o_any_req (w_any_req)
   );

   // Arbitration/sequencing FSM; every output is a register written here.
   always_ff @(posedge clock_50mhz or negedge reset_pin) begin
      if (!reset_pin) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_owner       <= '0;
         r_req_ack     <= '0;
         r_tx_data     <= '0;
         r_tx_start    <= 1'b0;
         r_active      <= 1'b0;
         r_timeout_err <= 1'b0;
         r_gap_cnt     <= '0;
         r_wdog_cnt    <= '0;
      end else begin
         // Pulse outputs default low; a state sets them for exactly one cycle.
         r_req_ack     <= '0;
         r_tx_start    <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_tx_data          <= req_data[int'(w_grant)*DATA_W +: DATA_W];
                  r_owner            <= w_grant;
                  r_req_ack[w_grant] <= 1'b1;
                  r_rr_ptr           <= (int'(w_grant) == N_REQ - 1) ? '0 : w_grant + 1'b1;
                  r_active           <= 1'b1;
                  r_state            <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Never start a frame on top of one the core is still shifting.
               if (!tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_wdog_cnt <= '0;
                  r_state    <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (tx_done || (r_wdog_cnt == CNT_W'(TO_LAST))) begin
                  r_timeout_err <= !tx_done;
                  if (GAP_CYCLES == 0) begin
                     r_active <= 1'b0;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_gap_cnt <= '0;
                     r_state   <= ST_GAP;
                  end
               end else begin
                  r_wdog_cnt <= r_wdog_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == CNT_W'(GAP_LAST)) begin
                  r_active <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: begin
               r_active <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ack     = r_req_ack;
   assign tx_data     = r_tx_data;
   assign tx_start    = r_tx_start;
   assign owner       = r_owner;
   assign active      = r_active;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a default-parameter instance exercised through a
// grant table plus hand-written busy/timeout/reset sequences, and a zero-gap
// instance for back-to-back spacing.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        tx_done;
   logic [1:0]  owner;
   logic        active;
   logic        timeout_err;

   logic [3:0]  z_req;
   logic [31:0] z_req_data;
   logic [3:0]  z_req_ack;
   logic [7:0]  z_tx_data;
   logic        z_tx_start;
   logic        z_tx_busy;
   logic        z_tx_done;
   logic [1:0]  z_owner;
   logic        z_active;
   logic        z_timeout_err;

   uart_tx_arbiter #(
      .N_REQ(4), .DATA_W(8), .GAP_CYCLES(434), .TIMEOUT_CYCLES(5000)
   ) dut (
      .clock_50mhz(clk), .reset_pin(rst_n), .req(req), .req_data(req_data),
      .req_ack(req_ack), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_done(tx_done), .owner(owner), .active(active),
      .timeout_err(timeout_err)
   );

   uart_tx_arbiter #(
      .N_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(5000)
   ) dut_nogap (
      .clock_50mhz(clk), .reset_pin(rst_n), .req(z_req), .req_data(z_req_data),
      .req_ack(z_req_ack), .tx_data(z_tx_data), .tx_start(z_tx_start),
      .tx_busy(z_tx_busy), .tx_done(z_tx_done), .owner(z_owner), .active(z_active),
      .timeout_err(z_timeout_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] own;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [3:0] mask;
      logic [1:0] own;
      logic [7:0] data;
   } vec_t;
   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_ack(input int bound, output logic [3:0] ack, output int n);
      ack = '0;
      n = 0;
      while (n < bound) begin
         @(negedge clk);
         n++;
         if (req_ack != 0) begin
            ack = req_ack;
            break;
         end
      end
   endtask

   task automatic wait_start(input int bound, output int n);
      n = 0;
      while (n < bound) begin
         @(negedge clk);
         n++;
         if (tx_start) break;
      end
   endtask

   task automatic wait_idle(input int bound, output int n);
      n = 0;
      while (n < bound) begin
         @(negedge clk);
         n++;
         if (!active) break;
      end
   endtask

   // Scoreboard and handshake monitor for the main instance.
   logic [3:0] prev_ack = '0;
   int         acks_since_start = 0;
   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         if (prev_ack != 0) check("ack_one_cycle", {28'd0, req_ack}, 32'd0);
         if (req_ack != 0) begin
            check("ack_onehot", {31'd0, $onehot(req_ack)}, 32'd1);
            check("ack_per_frame", acks_since_start, 0);
            acks_since_start++;
         end
         if (tx_start) begin
            acks_since_start = 0;
            if (sb_q.size() == 0) begin
               check("sb_underflow", sb_q.size(), 1);
            end else begin
               e = sb_q.pop_front();
               check("sb_tx_data", {24'd0, tx_data}, {24'd0, e.data});
               check("sb_owner", {30'd0, owner}, {30'd0, e.own});
            end
         end
         prev_ack = req_ack;
      end else begin
         prev_ack = '0;
         acks_since_start = 0;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL global_timeout: simulation time %0t exceeded", $time);
      $fatal(1, "bench did not complete");
   end

   initial begin
      logic [3:0] ack;
      int         n;
      int         bad_start;
      int         bad_data;

      vecs[0]  = '{4'hF,    2'd0, 8'h30};
      vecs[1]  = '{4'hF,    2'd1, 8'h31};
      vecs[2]  = '{4'hF,    2'd2, 8'h32};
      vecs[3]  = '{4'hF,    2'd3, 8'h33};
      vecs[4]  = '{4'hF,    2'd0, 8'h30};
      vecs[5]  = '{4'b1010, 2'd1, 8'h31};
      vecs[6]  = '{4'b1010, 2'd3, 8'h33};
      vecs[7]  = '{4'b0001, 2'd0, 8'h30};
      vecs[8]  = '{4'b0110, 2'd1, 8'h31};
      vecs[9]  = '{4'b1001, 2'd3, 8'h33};
      vecs[10] = '{4'b0100, 2'd2, 8'h32};

      rst_n = 1'b0;
      req = '0; req_data = {8'h33, 8'h32, 8'h31, 8'h30};
      tx_busy = 1'b0; tx_done = 1'b0;
      z_req = '0; z_req_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
      z_tx_busy = 1'b0; z_tx_done = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ack", {28'd0, req_ack}, 32'd0);
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_owner", {30'd0, owner}, 32'd0);
      check("rst_active", {31'd0, active}, 32'd0);
      check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven grant order from rr_ptr = 0
      for (int i = 0; i < 11; i++) begin
         req = vecs[i].mask;
         sb_q.push_back('{vecs[i].data, vecs[i].own});
         wait_ack(50, ack, n);
         check("tbl_ack", {28'd0, ack}, {28'd0, 4'b0001 << vecs[i].own});
         check("tbl_ack_latency", n, 1);
         wait_start(50, n);
         check("tbl_start_latency", n, 1);
         repeat (20) @(negedge clk);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         wait_idle(1000, n);
         check("tbl_back_to_idle", {31'd0, active}, 32'd0);
      end
      req = '0;
      @(negedge clk);

      // Single request on lane 2 with a full-length frame and gap
      req_data[23:16] = 8'h41;
      req = 4'b0100;
      sb_q.push_back('{8'h41, 2'd2});
      @(negedge clk);
      check("single_ack", {28'd0, req_ack}, 32'h4);
      check("single_active", {31'd0, active}, 32'd1);
      req = '0;
      @(negedge clk);
      check("single_start", {31'd0, tx_start}, 32'd1);
      check("single_tx_data", {24'd0, tx_data}, 32'h41);
      check("single_owner", {30'd0, owner}, 32'd2);
      repeat (4339) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (433) @(negedge clk);
      check("gap_still_active", {31'd0, active}, 32'd1);
      @(negedge clk);
      check("gap_done_idle", {31'd0, active}, 32'd0);

      // Busy hold on lane 0
      tx_busy = 1'b1;
      req_data[7:0] = 8'h5A;
      req = 4'b0001;
      sb_q.push_back('{8'h5A, 2'd0});
      wait_ack(50, ack, n);
      check("busy_ack", {28'd0, ack}, 32'h1);
      req = '0;
      bad_start = 0;
      bad_data = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_start) bad_start++;
         if (tx_data !== 8'h5A) bad_data++;
      end
      check("busy_no_start", bad_start, 0);
      check("busy_data_stable", bad_data, 0);
      tx_busy = 1'b0;
      @(negedge clk);
      check("busy_release_start", {31'd0, tx_start}, 32'd1);
      repeat (20) @(negedge clk);
      check("busy_data_held", {24'd0, tx_data}, 32'h5A);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      wait_idle(1000, n);

      // Watchdog: lane 1 never completes, lane 3 waits behind it
      req_data[15:8] = 8'h77;
      req = 4'b0010;
      sb_q.push_back('{8'h77, 2'd1});
      sb_q.push_back('{8'h99, 2'd3});
      wait_ack(50, ack, n);
      check("to_first_ack", {28'd0, ack}, 32'h2);
      req_data[31:24] = 8'h99;
      req = 4'b1000;
      wait_start(10, n);
      check("to_start_latency", n, 1);
      n = 0;
      while (n < 6000) begin
         @(negedge clk);
         n++;
         if (timeout_err) break;
      end
      check("to_latency", n, 5000);
      @(negedge clk);
      check("to_single_pulse", {31'd0, timeout_err}, 32'd0);
      wait_ack(1000, ack, n);
      check("to_next_ack", {28'd0, ack}, 32'h8);
      req = '0;
      wait_start(10, n);
      check("to_next_start", {31'd0, tx_start}, 32'd1);
      repeat (20) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("to_no_err_on_done", {31'd0, timeout_err}, 32'd0);
      wait_idle(1000, n);

      // Mid-frame reset, then rr_ptr restarts from 0
      req_data[23:16] = 8'h41;
      req = 4'b0100;
      sb_q.push_back('{8'h41, 2'd2});
      wait_ack(50, ack, n);
      req = '0;
      wait_start(10, n);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_async_outputs",
               {15'd0, req_ack, tx_start, tx_data, owner, active, timeout_err}, 32'd0);
      @(negedge clk);
      req = 4'b1010;
      sb_q.push_back('{8'h77, 2'd1});
      rst_n = 1'b1;
      wait_ack(5, ack, n);
      check("rst_resume_ack", {28'd0, ack}, 32'h2);
      check("rst_resume_latency", n, 1);
      req = '0;
      wait_start(10, n);
      repeat (20) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      wait_idle(1000, n);

      // Zero-gap instance: back-to-back frames
      z_req = 4'b0011;
      n = 0;
      while (n < 20 && !z_tx_start) begin
         @(negedge clk);
         n++;
      end
      check("nogap_first_latency", n, 2);
      check("nogap_first_data", {24'd0, z_tx_data}, 32'hB0);
      repeat (5) @(negedge clk);
      z_tx_done = 1'b1;
      @(negedge clk);
      z_tx_done = 1'b0;
      n = 1;
      check("nogap_idle_after_done", {31'd0, z_active}, 32'd0);
      while (n < 20 && !z_tx_start) begin
         @(negedge clk);
         n++;
      end
      check("nogap_restart_spacing", n, 3);
      check("nogap_second_data", {24'd0, z_tx_data}, 32'hB1);
      z_req = '0;
      repeat (5) @(negedge clk);
      z_tx_done = 1'b1;
      @(negedge clk);
      z_tx_done = 1'b0;
      @(negedge clk);
      check("nogap_final_idle", {31'd0, z_active}, 32'd0);

      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
